regfile_wb_arbiter: RTL and testbench

//  Write-side front end of the integer register file. Merges ALU results and LSU load results into the single regfile write port.
//  ALU: fixed priority, never stalled. LSU: valid/ready, buffered in a small FIFO.

---
 rtl/rv_core_pkg.sv | 16 +
 rtl/wb_fifo.sv | 84 ++++++++
 rtl/regfile_wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_core_pkg.sv
// Shared definitions for the integer register-file write-back path.
//   WIDTH        : register data width
//   ADRESS_WIDTH : register index width
//   wb_entry_t   : one buffered write {killed, rd, data}
package rv_core_pkg;

  localparam int unsigned WIDTH        = 32;
  localparam int unsigned ADRESS_WIDTH = 5;

  typedef struct packed {
    logic                    killed;
    logic [ADRESS_WIDTH-1:0] rd;
    logic [WIDTH-1:0]        data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending LSU register writes.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   push_i          write push_entry_i at the tail (ignored when full)
//   push_entry_i    entry to enqueue (killed bit may already be set)
//   pop_i           drop the head entry (ignored when empty)
//   kill_i/kill_rd_i mark every occupied entry with rd==kill_rd_i as killed
//   full_o/empty_o/count_o  occupancy status (killed entries still count)
//   head_o          entry at the head
//   live_o/rd_o     per-slot taps: slot occupied and not killed / slot rd
module wb_fifo
  import rv_core_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  wb_entry_t               push_entry_i,
  input  logic                    pop_i,
  input  logic                    kill_i,
  input  logic [ADRESS_WIDTH-1:0] kill_rd_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [CW-1:0]           count_o,
  output wb_entry_t               head_o,
  output logic [DEPTH-1:0]        live_o,
  output logic [ADRESS_WIDTH-1:0] rd_o [DEPTH]
);

  wb_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [DEPTH-1:0]  occ;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // A slot is occupied when its distance from the read pointer (mod DEPTH)
  // is below the current count.
  always_comb begin
    occ = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occ[i]   = ({1'b0, PW'(i) - rd_ptr_q} < count_q);
      live_o[i] = occ[i] & ~mem_q[i].killed;
      rd_o[i]   = mem_q[i].rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (kill_i && occ[i] && (mem_q[i].rd == kill_rd_i)) mem_q[i].killed <= 1'b1;
      end
      // The tail slot is never occupied when a push is accepted, so it
      // cannot collide with the kill update above.
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-side front end of the integer register file.
// Merges ALU results (fixed priority, never stalled) and LSU load results
// (valid/ready, buffered in wb_fifo) into one registered write port.
// Queued LSU writes superseded by a later ALU write to the same rd are
// killed and later popped silently. Provides pending-write queries.
// Optional feature macro: WB_BYPASS_EN (drives byp_hit*/byp_data* from wb_*).
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data     ALU result (always accepted)
//   lsu_valid/lsu_ready/lsu_rd/lsu_data  LSU load result handshake
//   wb_we/wb_addr/wb_data         registered regfile write port
//   q_addr0/1 -> q_pend0/1        live pending write for that register
//   byp_hit0/1, byp_data0/1       bypass of the write landing next edge
//   fifo_count                    occupied FIFO entries (incl. killed)
module regfile_wb_arbiter
  import rv_core_pkg::*;
#(
  parameter int unsigned WIDTH        = rv_core_pkg::WIDTH,
  parameter int unsigned ADRESS_WIDTH = rv_core_pkg::ADRESS_WIDTH,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  input  logic [ADRESS_WIDTH-1:0]       alu_rd,
  input  logic [WIDTH-1:0]              alu_data,
  input  logic                          lsu_valid,
  output logic                          lsu_ready,
  input  logic [ADRESS_WIDTH-1:0]       lsu_rd,
  input  logic [WIDTH-1:0]              lsu_data,
  output logic                          wb_we,
  output logic [ADRESS_WIDTH-1:0]       wb_addr,
  output logic [WIDTH-1:0]              wb_data,
  input  logic [ADRESS_WIDTH-1:0]       q_addr0,
  input  logic [ADRESS_WIDTH-1:0]       q_addr1,
  output logic                          q_pend0,
  output logic                          q_pend1,
  output logic                          byp_hit0,
  output logic                          byp_hit1,
  output logic [WIDTH-1:0]              byp_data0,
  output logic [WIDTH-1:0]              byp_data1,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic                    wb_we_q, wb_we_d;
  logic [ADRESS_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0]        wb_data_q, wb_data_d;

  logic                    alu_take;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic [CW-1:0]           count;
  wb_entry_t               push_entry;
  wb_entry_t               head;
  logic [FIFO_DEPTH-1:0]   live;
  logic [ADRESS_WIDTH-1:0] rd_tap [FIFO_DEPTH];

  assign alu_take  = alu_valid & (alu_rd != '0);
  assign lsu_ready = ~full;
  assign push      = lsu_valid & ~full & (lsu_rd != '0);
  // A killed head is discarded even while the ALU owns the port.
  assign pop       = ~empty & (head.killed | ~alu_take);

  // An LSU result arriving with a same-rd ALU write is the older value.
  always_comb begin
    push_entry        = '0;
    push_entry.killed = alu_take & (alu_rd == lsu_rd);
    push_entry.rd     = lsu_rd;
    push_entry.data   = lsu_data;
  end

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .kill_i       (alu_take),
    .kill_rd_i    (alu_rd),
    .full_o       (full),
    .empty_o      (empty),
    .count_o      (count),
    .head_o       (head),
    .live_o       (live),
    .rd_o         (rd_tap)
  );

  always_comb begin
    wb_we_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (alu_take) begin
      wb_we_d   = 1'b1;
      wb_addr_d = alu_rd;
      wb_data_d = alu_data;
    end else if (~empty && ~head.killed) begin
      wb_we_d   = 1'b1;
      wb_addr_d = head.rd;
      wb_data_d = head.data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_we      = wb_we_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign fifo_count = count;

  always_comb begin
    q_pend0 = wb_we_q & (wb_addr_q == q_addr0);
    q_pend1 = wb_we_q & (wb_addr_q == q_addr1);
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      q_pend0 = q_pend0 | (live[i] & (rd_tap[i] == q_addr0));
      q_pend1 = q_pend1 | (live[i] & (rd_tap[i] == q_addr1));
    end
    if (q_addr0 == '0) q_pend0 = 1'b0;
    if (q_addr1 == '0) q_pend1 = 1'b0;
  end

`ifdef WB_BYPASS_EN
  assign byp_hit0  = wb_we_q & (wb_addr_q == q_addr0) & (q_addr0 != '0);
  assign byp_hit1  = wb_we_q & (wb_addr_q == q_addr1) & (q_addr1 != '0);
  assign byp_data0 = wb_data_q;
  assign byp_data1 = wb_data_q;
`else
  assign byp_hit0  = 1'b0;
  assign byp_hit1  = 1'b0;
  assign byp_data0 = '0;
  assign byp_data1 = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, wb_addr, q_addr0, q_addr1;
  logic [31:0] alu_data, lsu_data, wb_data, byp_data0, byp_data1;
  logic        wb_we, q_pend0, q_pend1, byp_hit0, byp_hit1;
  logic [2:0]  fifo_count;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .WIDTH        (32),
    .ADRESS_WIDTH (5),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .q_addr0    (q_addr0),
    .q_addr1    (q_addr1),
    .q_pend0    (q_pend0),
    .q_pend1    (q_pend1),
    .byp_hit0   (byp_hit0),
    .byp_hit1   (byp_hit1),
    .byp_data0  (byp_data0),
    .byp_data1  (byp_data1),
    .fifo_count (fifo_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
  endtask

  task automatic test_reset();
    rst = 0; idle(); q_addr0 = 0; q_addr1 = 0;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h1234;
    repeat (3) tick();
    vec++; if (wb_we !== 1'b0) begin errs++; $display("FAIL reset_we got %0b exp 0", wb_we); end
    vec++; if (fifo_count !== 3'd0) begin errs++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    vec++; if (lsu_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %0b exp 1", lsu_ready); end
    vec++; if (wb_addr !== 5'd0 || wb_data !== 32'd0) begin errs++; $display("FAIL reset_wb got %0d/%h exp 0/0", wb_addr, wb_data); end
    idle();
    #2 rst = 1;
    tick();
  endtask

  task automatic test_alu();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    tick();
    vec++; if (wb_we !== 1'b1 || wb_addr !== 5'd5 || wb_data !== 32'hDEADBEEF) begin
      errs++; $display("FAIL alu_x5 got we=%0b a=%0d d=%h exp 1/5/deadbeef", wb_we, wb_addr, wb_data); end
    alu_rd = 0; alu_data = 32'h77;
    tick();
    vec++; if (wb_we !== 1'b0) begin errs++; $display("FAIL alu_x0 got we=%0b exp 0", wb_we); end
    idle();
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h99;
    tick();
    vec++; if (fifo_count !== 3'd0 || lsu_ready !== 1'b1 || wb_we !== 1'b0) begin
      errs++; $display("FAIL lsu_x0 got cnt=%0d rdy=%0b we=%0b exp 0/1/0", fifo_count, lsu_ready, wb_we); end
    idle();
    tick();
  endtask

  task automatic test_fill();
    q_addr0 = 12;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 5'(i + 1); alu_data = 32'(i);
      lsu_valid = 1; lsu_rd = 5'(10 + i); lsu_data = 32'h100 + 32'(i);
      tick();
      vec++; if (fifo_count !== 3'(i + 1) || wb_addr !== 5'(i + 1)) begin
        errs++; $display("FAIL fill_%0d got cnt=%0d a=%0d exp %0d/%0d", i, fifo_count, wb_addr, i + 1, i + 1); end
    end
    vec++; if (lsu_ready !== 1'b0) begin errs++; $display("FAIL full_ready got %0b exp 0", lsu_ready); end
    vec++; if (q_pend0 !== 1'b1) begin errs++; $display("FAIL fill_pend got %0b exp 1", q_pend0); end
    alu_rd = 5; lsu_rd = 14; lsu_data = 32'hBAD;
    tick();
    vec++; if (fifo_count !== 3'd4 || lsu_ready !== 1'b0) begin
      errs++; $display("FAIL full_hold got cnt=%0d rdy=%0b exp 4/0", fifo_count, lsu_ready); end
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      vec++; if (wb_we !== 1'b1 || wb_addr !== 5'(10 + i) || wb_data !== 32'h100 + 32'(i) || fifo_count !== 3'(3 - i)) begin
        errs++; $display("FAIL drain_%0d got we=%0b a=%0d d=%h cnt=%0d exp 1/%0d/%h/%0d",
                         i, wb_we, wb_addr, wb_data, fifo_count, 10 + i, 32'h100 + 32'(i), 3 - i); end
      vec++; if (lsu_ready !== 1'b1) begin errs++; $display("FAIL drain_ready_%0d got %0b exp 1", i, lsu_ready); end
    end
    tick();
    vec++; if (wb_we !== 1'b0 || q_pend0 !== 1'b0) begin
      errs++; $display("FAIL drain_end got we=%0b pend=%0b exp 0/0", wb_we, q_pend0); end
  endtask

  task automatic test_waw();
    q_addr0 = 7;
    alu_valid = 1; alu_rd = 1; alu_data = 32'h1;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h11;
    tick();
    vec++; if (fifo_count !== 3'd1 || q_pend0 !== 1'b1) begin
      errs++; $display("FAIL waw_queued got cnt=%0d pend=%0b exp 1/1", fifo_count, q_pend0); end
    lsu_valid = 0; alu_rd = 7; alu_data = 32'h22;
    tick();
    vec++; if (wb_we !== 1'b1 || wb_addr !== 5'd7 || wb_data !== 32'h22 || fifo_count !== 3'd1) begin
      errs++; $display("FAIL waw_alu got we=%0b a=%0d d=%h cnt=%0d exp 1/7/22/1", wb_we, wb_addr, wb_data, fifo_count); end
    vec++; if (q_pend0 !== 1'b1) begin errs++; $display("FAIL waw_pend_wb got %0b exp 1", q_pend0); end
    idle();
    tick();
    vec++; if (wb_we !== 1'b0 || fifo_count !== 3'd0 || q_pend0 !== 1'b0) begin
      errs++; $display("FAIL waw_kill got we=%0b cnt=%0d pend=%0b exp 0/0/0", wb_we, fifo_count, q_pend0); end
    tick();
    vec++; if (wb_we !== 1'b0) begin errs++; $display("FAIL waw_nolate got we=%0b d=%h exp 0", wb_we, wb_data); end
  endtask

  task automatic test_conflict();
    q_addr1 = 9;
    alu_valid = 1; alu_rd = 9; alu_data = 32'hBB;
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'hAA;
    tick();
    vec++; if (wb_we !== 1'b1 || wb_addr !== 5'd9 || wb_data !== 32'hBB || fifo_count !== 3'd1) begin
      errs++; $display("FAIL conflict_alu got we=%0b a=%0d d=%h cnt=%0d exp 1/9/bb/1", wb_we, wb_addr, wb_data, fifo_count); end
    idle();
    tick();
    vec++; if (wb_we !== 1'b0 || fifo_count !== 3'd0 || q_pend1 !== 1'b0) begin
      errs++; $display("FAIL conflict_kill got we=%0b cnt=%0d pend=%0b exp 0/0/0", wb_we, fifo_count, q_pend1); end
    q_addr1 = 0;
  endtask

  task automatic test_back_to_back();
    lsu_valid = 1; lsu_rd = 20; lsu_data = 32'hA1;
    tick();
    vec++; if (wb_we !== 1'b0 || fifo_count !== 3'd1) begin
      errs++; $display("FAIL b2b_first got we=%0b cnt=%0d exp 0/1", wb_we, fifo_count); end
    lsu_rd = 21; lsu_data = 32'hA2;
    tick();
    vec++; if (wb_we !== 1'b1 || wb_addr !== 5'd20 || wb_data !== 32'hA1 || fifo_count !== 3'd1) begin
      errs++; $display("FAIL b2b_pushpop got we=%0b a=%0d d=%h cnt=%0d exp 1/20/a1/1", wb_we, wb_addr, wb_data, fifo_count); end
    idle();
    tick();
    vec++; if (wb_we !== 1'b1 || wb_addr !== 5'd21 || wb_data !== 32'hA2 || fifo_count !== 3'd0) begin
      errs++; $display("FAIL b2b_second got we=%0b a=%0d d=%h cnt=%0d exp 1/21/a2/0", wb_we, wb_addr, wb_data, fifo_count); end
    tick();
  endtask

  task automatic test_bypass();
    q_addr0 = 3;
    alu_valid = 1; alu_rd = 3; alu_data = 32'h55;
    tick();
    idle();
`ifdef WB_BYPASS_EN
    vec++; if (byp_hit0 !== 1'b1 || byp_data0 !== 32'h55) begin
      errs++; $display("FAIL bypass_on got hit=%0b d=%h exp 1/55", byp_hit0, byp_data0); end
`else
    vec++; if (byp_hit0 !== 1'b0 || byp_data0 !== 32'h0) begin
      errs++; $display("FAIL bypass_off got hit=%0b d=%h exp 0/0", byp_hit0, byp_data0); end
`endif
    vec++; if (byp_hit1 !== 1'b0) begin errs++; $display("FAIL bypass_other got %0b exp 0", byp_hit1); end
    tick();
  endtask

  task automatic test_reset_mid();
    alu_valid = 1; alu_rd = 1; alu_data = 32'h1;
    lsu_valid = 1; lsu_rd = 20; lsu_data = 32'hC0;
    tick();
    lsu_rd = 21;
    tick();
    vec++; if (fifo_count !== 3'd2) begin errs++; $display("FAIL mid_setup got cnt=%0d exp 2", fifo_count); end
    idle();
    #2 rst = 0;
    #1;
    vec++; if (fifo_count !== 3'd0 || wb_we !== 1'b0 || lsu_ready !== 1'b1) begin
      errs++; $display("FAIL mid_reset got cnt=%0d we=%0b rdy=%0b exp 0/0/1", fifo_count, wb_we, lsu_ready); end
    #1 rst = 1;
    tick();
    tick();
    vec++; if (wb_we !== 1'b0) begin errs++; $display("FAIL mid_nodrain got we=%0b a=%0d exp 0", wb_we, wb_addr); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_fill();
    test_waw();
    test_conflict();
    test_back_to_back();
    test_bypass();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
